// File: rtl/inv_pkg.sv
// Shared definitions for the inverter stage: operating-mode encoding.
package inv_pkg;

   typedef enum logic [1:0] {
      MODE_PASS  = 2'b00,
      MODE_INV   = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_MASK  = 2'b11
   } mode_e;

endpackage

// File: rtl/inv_stage_phase_div.sv
// Free-running blink phase divider: toggles phase every `period` cycles.
// A period of 0 freezes the phase.
module phase_div #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] period,
   output logic             phase
);

   logic [DIV_W-1:0] cnt_reg;
   logic             phase_reg;
   logic [DIV_W-1:0] last_cnt;

   assign last_cnt = period - DIV_W'(1);
   assign phase    = phase_reg;

   // Compare with >= so a period shrunk below the current count wraps at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg   <= '0;
         phase_reg <= 1'b0;
      end else if (period == '0) begin
         cnt_reg   <= '0;
      end else if (cnt_reg >= last_cnt) begin
         cnt_reg   <= '0;
         phase_reg <= ~phase_reg;
      end else begin
         cnt_reg   <= cnt_reg + DIV_W'(1);
      end
   end

endmodule

// File: rtl/inv_stage.sv
// Registered pass/invert/mask/blink data stage with a single valid/ready
// pipeline register and a free-running blink phase.
module inv_stage
   import inv_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] mask,
   input  logic [DIV_W-1:0] period,
   output logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             phase
);

   logic [WIDTH-1:0] y_reg;
   logic [WIDTH-1:0] y_next;
   logic             out_valid_reg;
   logic             fire_in;

   phase_div #(
      .DIV_W (DIV_W)
   ) u_phase_div (
      .clk    (clk),
      .rst    (rst),
      .period (period),
      .phase  (phase)
   );

   // Ready only looks at the output register, never at in_valid.
   assign in_ready  = !out_valid_reg || out_ready;
   assign fire_in   = in_valid && in_ready;
   assign y         = y_reg;
   assign out_valid = out_valid_reg;

   always_comb begin
      y_next = a;
      case (mode_e'(mode))
         MODE_PASS:  y_next = a;
         MODE_INV:   y_next = ~a;
         MODE_BLINK: y_next = phase ? ~a : a;
         MODE_MASK:  y_next = a ^ mask;
         default:    y_next = a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_reg         <= '0;
         out_valid_reg <= 1'b0;
      end else if (fire_in) begin
         y_reg         <= y_next;
         out_valid_reg <= 1'b1;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inv_stage.sv
// Scoreboard bench for inv_stage: a transaction-level model queues expected
// words on accept; a negedge monitor compares whatever the DUT presents.
module tb_inv_stage;

   localparam int WIDTH = 8;
   localparam int DIV_W = 24;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] a;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       mode;
   logic [WIDTH-1:0] mask;
   logic [DIV_W-1:0] period;
   logic [WIDTH-1:0] y;
   logic             out_valid;
   logic             out_ready;
   logic             phase;

   int checks = 0;
   int errors = 0;

   inv_stage #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a         (a),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mode      (mode),
      .mask      (mask),
      .period    (period),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .phase     (phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   // Reference model: a queue of words in flight plus the blink phase,
   // expressed as "cycles elapsed since the last toggle".
   logic [WIDTH-1:0] exp_q[$];
   bit               m_phase;
   int               m_elapsed;
   bit               m_drain, m_fire;
   logic [WIDTH-1:0] m_word;
   bit               mon_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_phase   = 1'b0;
         m_elapsed = 0;
      end else begin
         m_drain = (exp_q.size() != 0) && out_ready;
         m_fire  = in_valid && ((exp_q.size() == 0) || out_ready);
         case (mode)
            2'd0:    m_word = a;
            2'd1:    m_word = ~a;
            2'd2:    m_word = m_phase ? ~a : a;
            default: m_word = a ^ mask;
         endcase
         if (m_drain) void'(exp_q.pop_front());
         if (m_fire) exp_q.push_back(m_word);
         if (period == '0) begin
            m_elapsed = 0;
         end else if (m_elapsed + 1 >= int'(period)) begin
            m_phase   = ~m_phase;
            m_elapsed = 0;
         end else begin
            m_elapsed++;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
         chk("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
         chk("phase", 32'(phase), 32'(m_phase));
         if (exp_q.size() != 0) chk("y", 32'(y), 32'(exp_q[0]));
      end
   end

   task automatic drv(input logic v, input logic [1:0] m, input logic [7:0] aa,
                      input logic [7:0] mk, input logic orr);
      in_valid  = v;
      mode      = m;
      a         = aa;
      mask      = mk;
      out_ready = orr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int guard;
      rst = 1'b1; in_valid = 1'b1; mode = 2'd0; a = 8'hFF; mask = 8'h00;
      period = '0; out_ready = 1'b1;
      @(posedge clk);
      mon_en = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      in_valid = 1'b0;
      chk("y_reset", 32'(y), 32'h0);
      chk("valid_reset", 32'(out_valid), 32'h0);
      chk("ready_after_reset", 32'(in_ready), 32'h1);

      // Basic modes, full throughput
      drv(1'b1, 2'd0, 8'hA5, 8'h00, 1'b1);
      chk("pass_A5", 32'(y), 32'hA5);
      drv(1'b1, 2'd1, 8'hA5, 8'h00, 1'b1);
      chk("inv_A5", 32'(y), 32'h5A);
      drv(1'b1, 2'd3, 8'hA5, 8'h0F, 1'b1);
      chk("mask_A5", 32'(y), 32'hAA);
      drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

      // Backpressure: held word stays put while inputs wander
      drv(1'b1, 2'd1, 8'h3C, 8'h00, 1'b0);
      chk("bp_y", 32'(y), 32'hC3);
      for (int i = 0; i < 5; i++) begin
         drv(1'b1, 2'd0, 8'($urandom), 8'($urandom), 1'b0);
         chk("bp_hold_y", 32'(y), 32'hC3);
         chk("bp_in_ready", 32'(in_ready), 32'h0);
      end
      drv(1'b1, 2'd0, 8'h11, 8'h00, 1'b1);
      chk("bp_drain_accept", 32'(y), 32'h11);
      drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

      // Blink at period 3, then frozen with period 0
      period = 24'd3;
      for (int i = 0; i < 12; i++) drv(1'b1, 2'd2, 8'h00, 8'h00, 1'b1);
      period = 24'd0;
      for (int i = 0; i < 6; i++) drv(1'b1, 2'd2, 8'h00, 8'h00, 1'b1);

      // Period shrink mid-count
      period = 24'd10;
      guard = 0;
      while (m_elapsed != 7 && guard < 40) begin
         drv(1'b1, 2'd2, 8'h00, 8'h00, 1'b1);
         guard++;
      end
      chk("shrink_reached_cnt7", 32'(m_elapsed), 32'd7);
      period = 24'd4;
      for (int i = 0; i < 12; i++) drv(1'b1, 2'd2, 8'h00, 8'h00, 1'b1);

      // Reset while a word is held: it must never come out
      drv(1'b1, 2'd1, 8'h5A, 8'h00, 1'b0);
      rst = 1'b1;
      drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
      rst = 1'b0;
      chk("rst_hold_valid", 32'(out_valid), 32'h0);
      chk("rst_hold_y", 32'(y), 32'h0);
      chk("rst_hold_phase", 32'(phase), 32'h0);
      for (int i = 0; i < 3; i++) drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

      // Randomised traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) period = 24'($urandom_range(0, 6));
         rst = ($urandom_range(0, 99) == 0);
         drv(1'($urandom), 2'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) != 0));
         rst = 1'b0;
      end
      drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
      drv(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_stage.md
# inv_stage

Parametrised, registered successor to the single-bit combinational inverter: a WIDTH-bit data stage that passes, inverts, mask-inverts or periodically blinks (alternates invert/pass) its input. Data moves through one valid/ready pipeline register, so the block drops between any two streaming stages (switch/LED paths, test-pattern generators) without breaking backpressure. A free-running phase divider provides the blink rate.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DIV_W, 24, width of blink period counter (≥1)
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- a  in  WIDTH  input data word
- in_valid  in  1  a/mode/mask valid this cycle
- in_ready  out  1  stage can accept this cycle
- mode  in  2  00 PASS, 01 INV, 10 BLINK, 11 MASK; sampled with a
- mask  in  WIDTH  bits to invert in MASK mode; sampled with a
- period  in  DIV_W  blink half-period in cycles; 0 disables blink toggling
- y  out  WIDTH  registered output data
- out_valid  out  1  y valid
- out_ready  in  1  downstream accepts y
- phase  out  1  current blink phase (1 = inverting half)

## Operation
- Accept: fire_in = in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
- On fire_in: y <= f(a), out_valid <= 1. f by mode sampled same cycle: PASS a; INV ~a; MASK a ^ mask; BLINK phase ? ~a : a (phase value in the accept cycle).
- Output held stable while out_valid && !out_ready; a/mode/mask changes have no effect until next fire_in.
- out_valid clears when out_ready && !fire_in; simultaneous drain and accept keeps out_valid=1 with new y (full throughput, 1 word/cycle).
- Phase divider: cnt counts 0..period-1 every cycle regardless of handshake; on cnt==period-1, cnt<=0 and phase toggles. period==0: cnt<=0, phase held. period==1: phase toggles every cycle.
- period changed mid-count: if cnt ≥ new period-1, wrap on next cycle (cnt<=0, phase toggles); no overflow.
- Reset: y=0, out_valid=0, cnt=0, phase=0; in_ready=1 in the first cycle after reset. Reset mid-transfer discards the held word.
- All arithmetic unsigned, cnt is DIV_W bits, no sign extension anywhere.

## Timing
- Latency a→y: 1 cycle (y valid the cycle after fire_in).
- No combinational path a/mode/mask → y; only out_ready → in_ready is combinational.
- Phase toggles on the edge where cnt==period-1; BLINK words accepted that same cycle use the pre-toggle phase.
- Throughput 1 word/cycle with out_ready held high.

## Structure
- Shared package inv_pkg: mode constants MODE_PASS=2'b00, MODE_INV=2'b01, MODE_BLINK=2'b10, MODE_MASK=2'b11.
- Sub-module phase_div (params DIV_W; ports clk, rst, period, phase): counter and phase toggle; instantiated once.
- Top holds handshake register and the mode mux.

## Test plan
- Reset: assert rst 2 cycles with in_valid=1 → y=0, out_valid=0, phase=0; in_ready=1 first cycle after release.
- Modes, WIDTH=8, out_ready=1: a=8'hA5 PASS→y=8'hA5; INV→8'h5A; MASK mask=8'h0F→8'hAA, each one cycle after accept.
- Backpressure: accept 8'h3C INV, out_ready=0 for 5 cycles while a changes → y stays 8'hC3, in_ready=0; release → next word accepted same cycle as drain.
- Blink: period=3, BLINK, a=8'h00 every cycle → y sequence 00,00,00,FF,FF,FF,00… (phase toggles every 3 cycles); period=0 → y stays 8'h00.
- Period shrink: period=10, at cnt=7 set period=4 → wrap next cycle, phase toggles once, then every 4 cycles.
- Reset mid-hold: out_valid=1, out_ready=0, assert rst → out_valid=0, y=0 next cycle; held word never delivered.
